// File: rtl/w3op_pkg.sv
// Shared types for the w3op receive front end: opcodes, code-word field slices,
// the decoded-op record carried through the FIFO, and the sequencing states.
// Pure declarations; no logic, latency or flow control of its own.
package w3op_pkg;

    localparam int W3_AW  = 10;
    localparam int OPC_HI = 35;
    localparam int OPC_LO = 30;
    localparam int RD_HI  = 29;
    localparam int RD_LO  = 20;
    localparam int RA_HI  = 19;
    localparam int RA_LO  = 10;
    localparam int RB_HI  = 9;
    localparam int RB_LO  = 0;

    typedef enum logic [5:0] {
        OPC_NOP  = 6'h00,
        OPC_ADD  = 6'h01,
        OPC_SUB  = 6'h02,
        OPC_AND  = 6'h03,
        OPC_OR   = 6'h04,
        OPC_XOR  = 6'h05,
        OPC_MOV  = 6'h06,
        OPC_HALT = 6'h3F
    } opcode_e;

    typedef struct packed {
        logic [5:0]       op_code;
        logic [W3_AW-1:0] rd;
        logic [W3_AW-1:0] ra;
        logic [W3_AW-1:0] rb;
        logic             illegal;
    } dec_op_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [5:0] opc);
        case (opc)
            OPC_NOP, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_XOR, OPC_MOV, OPC_HALT: is_legal = 1'b1;
            default:                    is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/w3op_fifo.sv
// Generic synchronous FIFO of decoded ops; head entry is read straight from storage.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: push ignored while full, pop ignored while empty; a pop never frees a slot for the same edge.
module w3op_fifo
    import w3op_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  dec_op_t push_dat,
    input  logic    pop,
    output dec_op_t head_dat,
    output logic    full,
    output logic    empty,
    output logic    last
);

    localparam int PW = $clog2(DEPTH);

    dec_op_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign last     = (count == (PW+1)'(1));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage is cleared so the head fields read as zero straight out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/w3op_decode.sv
// Decodes 36-bit three-operand words into ops, drops NOPs, flags illegal opcodes, sequences HALT.
// Latency: a word accepted at edge N appears on op_* after edge N; no combinational code->op path.
// Backpressure: code_ready depends only on registered state (RUN and FIFO not full).
module w3op_decode
    import w3op_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = W3_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          code_valid,
    input  logic [35:0]   code,
    output logic          code_ready,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [5:0]    op_code,
    output logic [AW-1:0] op_rd,
    output logic [AW-1:0] op_ra,
    output logic [AW-1:0] op_rb,
    output logic          op_illegal,
    output logic          halted,
    output logic [31:0]   instr_count
);

    state_e     state;
    dec_op_t    dec_op;
    dec_op_t    head_op;
    logic [5:0] opc;
    logic       accept;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       last;

    assign opc        = code[OPC_HI:OPC_LO];
    assign code_ready = (state == ST_RUN) && !full;
    assign accept     = code_valid && code_ready;
    assign push       = accept && (opc != OPC_NOP);
    assign pop        = op_ready && !empty;

    always_comb begin
        dec_op.op_code = opc;
        dec_op.rd      = code[RD_HI:RD_LO];
        dec_op.ra      = code[RA_HI:RA_LO];
        dec_op.rb      = code[RB_HI:RB_LO];
        dec_op.illegal = !is_legal(opc);
        // MOV has no second source; the execute stage expects rb cleared.
        if (opc == OPC_MOV) begin
            dec_op.rb = '0;
        end
    end

    w3op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (dec_op),
        .pop      (pop),
        .head_dat (head_op),
        .full     (full),
        .empty    (empty),
        .last     (last)
    );

    assign op_valid   = !empty;
    assign op_code    = head_op.op_code;
    assign op_rd      = head_op.rd;
    assign op_ra      = head_op.ra;
    assign op_rb      = head_op.rb;
    assign op_illegal = head_op.illegal;

    // No pushes occur in DRAIN, so popping the last entry is the HALT leaving.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_RUN;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (accept && (instr_count != '1)) begin
                instr_count <= instr_count + 32'd1;
            end
            case (state)
                ST_RUN: begin
                    if (accept && (opc == OPC_HALT)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && last) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_w3op_decode.sv
// Bench for w3op_decode: decode table, full/HALT/reset sequences, randomized traffic.
// Expected behaviour comes from a queue-based model of the accept/emit rules.
module tb_w3op_decode;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [35:0] code;
    logic        code_ready;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  op_code;
    logic [9:0]  op_rd;
    logic [9:0]  op_ra;
    logic [9:0]  op_rb;
    logic        op_illegal;
    logic        halted;
    logic [31:0] instr_count;

    w3op_decode #(.DEPTH(DEPTH), .AW(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .code_valid  (code_valid),
        .code        (code),
        .code_ready  (code_ready),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_rd       (op_rd),
        .op_ra       (op_ra),
        .op_rb       (op_rb),
        .op_illegal  (op_illegal),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] opc;
        logic [9:0] rd;
        logic [9:0] ra;
        logic [9:0] rb;
        logic       ill;
    } m_op_t;

    typedef struct {
        logic [35:0] word;
        logic        vld;
        logic [5:0]  opc;
        logic [9:0]  rd;
        logic [9:0]  ra;
        logic [9:0]  rb;
        logic        ill;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    m_op_t       q[$];
    logic [31:0] m_count;
    logic        m_drain;
    logic        m_halted;
    logic [9:0]  seen_rd[$];
    vec_t        tbl[11];

    function automatic logic [35:0] mk(input logic [5:0] opc, input logic [9:0] rd,
                                       input logic [9:0] ra, input logic [9:0] rb);
        return {opc, rd, ra, rb};
    endfunction

    function automatic m_op_t model_dec(input logic [35:0] w);
        m_op_t o;
        o.opc = w[35:30];
        o.rd  = w[29:20];
        o.ra  = w[19:10];
        o.rb  = w[9:0];
        o.ill = !((o.opc <= 6'h06) || (o.opc == 6'h3F));
        if (o.opc == 6'h06) o.rb = '0;
        return o;
    endfunction

    function automatic logic m_ready();
        return !m_drain && !m_halted && (q.size() < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; code_valid = 1'b0; code = '0; op_ready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        q.delete();
        m_count = '0; m_drain = 1'b0; m_halted = 1'b0;
    endtask

    // One clock: check current outputs against the model, clock, then advance the model.
    task automatic cycle(input logic v, input logic [35:0] c, input logic r, output logic acc);
        logic  pop;
        m_op_t o;
        code_valid = v; code = c; op_ready = r;
        #1;
        chk("code_ready", 32'(code_ready), 32'(m_ready()));
        chk("op_valid", 32'(op_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("op_code", 32'(op_code), 32'(q[0].opc));
            chk("op_rd", 32'(op_rd), 32'(q[0].rd));
            chk("op_ra", 32'(op_ra), 32'(q[0].ra));
            chk("op_rb", 32'(op_rb), 32'(q[0].rb));
            chk("op_illegal", 32'(op_illegal), 32'(q[0].ill));
        end
        chk("halted", 32'(halted), 32'(m_halted));
        chk("instr_count", instr_count, m_count);
        acc = v && m_ready();
        pop = r && (q.size() != 0);
        if (pop) seen_rd.push_back(op_rd);
        @(posedge clock);
        if (pop) void'(q.pop_front());
        if (acc) begin
            o = model_dec(c);
            if (m_count != 32'hFFFF_FFFF) m_count++;
            if (o.opc != 6'h00) q.push_back(o);
            if (o.opc == 6'h3F) m_drain = 1'b1;
        end
        if (m_drain && q.size() == 0) m_halted = 1'b1;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [5:0] opc;

        tbl[0]  = '{mk(6'h01, 10'd1, 10'd2, 10'd3),      1'b1, 6'h01, 10'd1, 10'd2, 10'd3, 1'b0};
        tbl[1]  = '{mk(6'h02, 10'd4, 10'd5, 10'd6),      1'b1, 6'h02, 10'd4, 10'd5, 10'd6, 1'b0};
        tbl[2]  = '{mk(6'h06, 10'd7, 10'd8, 10'd9),      1'b1, 6'h06, 10'd7, 10'd8, 10'd0, 1'b0};
        tbl[3]  = '{mk(6'h00, 10'd0, 10'd0, 10'd0),      1'b0, 6'h00, 10'd0, 10'd0, 10'd0, 1'b0};
        tbl[4]  = '{mk(6'h05, 10'd10, 10'd11, 10'd12),   1'b1, 6'h05, 10'd10, 10'd11, 10'd12, 1'b0};
        tbl[5]  = '{mk(6'h00, 10'd1, 10'd1, 10'd1),      1'b0, 6'h00, 10'd0, 10'd0, 10'd0, 1'b0};
        tbl[6]  = '{mk(6'h2A, 10'd100, 10'd200, 10'd300), 1'b1, 6'h2A, 10'd100, 10'd200, 10'd300, 1'b1};
        tbl[7]  = '{mk(6'h03, 10'd1023, 10'd0, 10'd512), 1'b1, 6'h03, 10'd1023, 10'd0, 10'd512, 1'b0};
        tbl[8]  = '{mk(6'h04, 10'd5, 10'd6, 10'd7),      1'b1, 6'h04, 10'd5, 10'd6, 10'd7, 1'b0};
        tbl[9]  = '{mk(6'h07, 10'd1, 10'd2, 10'd3),      1'b1, 6'h07, 10'd1, 10'd2, 10'd3, 1'b1};
        tbl[10] = '{mk(6'h3F, 10'd3, 10'd2, 10'd1),      1'b1, 6'h3F, 10'd3, 10'd2, 10'd1, 1'b0};

        // Reset state
        do_reset();
        chk("rst code_ready", 32'(code_ready), 32'd1);
        chk("rst op_valid", 32'(op_valid), 32'd0);
        chk("rst op_illegal", 32'(op_illegal), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst instr_count", instr_count, 32'd0);
        chk("rst op_fields", {op_code, op_rd, op_ra, op_rb}, 32'd0);

        // Decode table, streamed back-to-back with op_ready high
        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].word, 1'b1, acc);
            chk($sformatf("tbl%0d valid", i), 32'(op_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d fields", i), {op_code, op_rd, op_ra, op_rb},
                    {tbl[i].opc, tbl[i].rd, tbl[i].ra, tbl[i].rb});
                chk($sformatf("tbl%0d illegal", i), 32'(op_illegal), 32'(tbl[i].ill));
            end
        end
        chk("tbl instr_count", instr_count, 32'd11);
        chk("tbl ready after halt", 32'(code_ready), 32'd0);
        cycle(1'b1, mk(6'h01, 10'd1, 10'd1, 10'd1), 1'b1, acc);
        chk("tbl halted", 32'(halted), 32'd1);
        chk("tbl count frozen", instr_count, 32'd11);

        // Fill to full with op_ready low, then drain with pointer wrap
        do_reset();
        seen_rd.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(6'h01, 10'(i + 1), 10'd0, 10'd0), 1'b0, acc);
        chk("full code_ready", 32'(code_ready), 32'd0);
        cycle(1'b1, mk(6'h01, 10'd5, 10'd0, 10'd0), 1'b0, acc);
        chk("full no accept", 32'(acc), 32'd0);
        for (int i = 4; i < 6; i++) begin
            acc = 1'b0;
            for (int k = 0; k < 10 && !acc; k++) cycle(1'b1, mk(6'h01, 10'(i + 1), 10'd0, 10'd0), 1'b1, acc);
            chk("full hold accepted", 32'(acc), 32'd1);
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, acc);
        chk("full pop count", 32'(seen_rd.size()), 32'd6);
        for (int i = 0; i < 6 && i < seen_rd.size(); i++) chk("full pop order", 32'(seen_rd[i]), 32'(i + 1));
        chk("full instr_count", instr_count, 32'd6);

        // HALT with a following OR held on the input
        do_reset();
        cycle(1'b1, mk(6'h01, 10'd1, 10'd2, 10'd3), 1'b0, acc);
        cycle(1'b1, mk(6'h3F, 10'd0, 10'd0, 10'd0), 1'b0, acc);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, mk(6'h04, 10'd9, 10'd9, 10'd9), 1'b0, acc);
            chk("halt ready low", 32'(code_ready), 32'd0);
        end
        cycle(1'b1, mk(6'h04, 10'd9, 10'd9, 10'd9), 1'b1, acc);
        chk("halt not yet", 32'(halted), 32'd0);
        cycle(1'b1, mk(6'h04, 10'd9, 10'd9, 10'd9), 1'b1, acc);
        chk("halt rises", 32'(halted), 32'd1);
        for (int k = 0; k < 3; k++) cycle(1'b1, mk(6'h04, 10'd9, 10'd9, 10'd9), 1'b1, acc);
        chk("halt OR dropped", instr_count, 32'd2);

        // Reset mid-drain with three entries queued
        do_reset();
        cycle(1'b1, mk(6'h01, 10'd1, 10'd1, 10'd1), 1'b0, acc);
        cycle(1'b1, mk(6'h02, 10'd2, 10'd2, 10'd2), 1'b0, acc);
        cycle(1'b1, mk(6'h3F, 10'd3, 10'd3, 10'd3), 1'b0, acc);
        chk("drain ready", 32'(code_ready), 32'd0);
        reset = 1'b1; code_valid = 1'b1; code = mk(6'h04, 10'd1, 10'd1, 10'd1); op_ready = 1'b1;
        @(posedge clock); #1;
        chk("mid rst op_valid", 32'(op_valid), 32'd0);
        chk("mid rst code_ready", 32'(code_ready), 32'd1);
        chk("mid rst halted", 32'(halted), 32'd0);
        chk("mid rst instr_count", instr_count, 32'd0);
        do_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: opc = 6'($urandom_range(0, 6));
                7:       opc = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'h01;
                default: opc = 6'($urandom_range(0, 63));
            endcase
            cycle($urandom_range(0, 3) != 0, mk(opc, 10'($urandom), 10'($urandom), 10'($urandom)),
                  $urandom_range(0, 2) != 0, acc);
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
